// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the reset sequencers: state encoding and a
// constant-evaluable ceil(log2) helper for sizing index registers.
package rst_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_ASSERT    = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_HOLD      = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4
   } state_e;

   // Smallest r with 2**r >= value; 0 for value <= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchronizer for a single level signal entering the clk domain.
// Both flops take RST_VAL while rst is high so the output is defined at once.
module cdc_sync_bit #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic sync1_d, sync1_q;
   logic sync2_d, sync2_q;

   // Shift the asynchronous input through two flops.
   always_comb begin
      sync1_d = d;
      sync2_d = sync1_q;
   end

   // Synchronizer flops, asynchronously forced to the reset value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= RST_VAL;
         sync2_q <= RST_VAL;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign q = sync2_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds every domain in reset until the synced PLL lock has
// been stable for LOCK_FILTER cycles, waits HOLD_CYCLES, then releases the
// domain resets in index order spaced GAP_CYCLES apart. Loss of lock (after
// acceptance) or a software request restarts the whole sequence.
module rst_seq_ctrl
   import rst_seq_ctrl_pkg::*;
#(
   parameter int N_DOM       = 3,
   parameter int LOCK_FILTER = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 8,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pll_locked,
   input  logic             sw_rst_req,
   output logic [N_DOM-1:0] dom_rst_out,
   output logic             all_ready,
   output logic             busy
);

   localparam int                IDX_W     = (N_DOM > 1) ? clog2(N_DOM) : 1;
   localparam longint            CNT_MAX   = (longint'(1) << CNT_W) - 1;
   localparam logic [CNT_W-1:0]  FILT_LAST = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DOM - 1);
   localparam logic [N_DOM-1:0]  ALL_ONES  = '1;

   // Reject builds whose counter cannot represent a configured delay.
   generate
      if (N_DOM < 1 || LOCK_FILTER < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1 ||
          CNT_W < 1 || CNT_W > 32 ||
          longint'(LOCK_FILTER) > CNT_MAX || longint'(HOLD_CYCLES) > CNT_MAX ||
          longint'(GAP_CYCLES) > CNT_MAX) begin : g_param_check
         $error("rst_seq_ctrl: illegal parameter set or CNT_W too small");
      end
   endgenerate

   // Counters stop at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic lock_s;

   cdc_sync_bit #(.RST_VAL(1'b0)) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   state_e             state_d,     state_q;
   logic [CNT_W-1:0]   filt_d,      filt_q;
   logic [CNT_W-1:0]   cnt_d,       cnt_q;
   logic [IDX_W-1:0]   idx_d,       idx_q;
   logic [N_DOM-1:0]   dom_rst_d,   dom_rst_q;
   logic               all_ready_d, all_ready_q;
   logic               busy_d,      busy_q;
   logic               abort;

   // Next-state, counter and registered-output logic; abort overrides all.
   always_comb begin
      state_d     = state_q;
      filt_d      = filt_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      dom_rst_d   = dom_rst_q;
      all_ready_d = 1'b0;
      busy_d      = 1'b1;

      // A restart request during ASSERT is redundant and is dropped.
      abort = (sw_rst_req && (state_q != ST_ASSERT)) ||
              (!lock_s && ((state_q == ST_HOLD) || (state_q == ST_RELEASE) ||
                           (state_q == ST_RUN)));

      if (abort) begin
         state_d   = ST_ASSERT;
         filt_d    = '0;
         cnt_d     = '0;
         idx_d     = '0;
         dom_rst_d = ALL_ONES;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               state_d   = ST_WAIT_LOCK;
               filt_d    = '0;
               cnt_d     = '0;
               idx_d     = '0;
               dom_rst_d = ALL_ONES;
            end
            ST_WAIT_LOCK: begin
               if (!lock_s) begin
                  filt_d = '0;
               end else if (filt_q == FILT_LAST) begin
                  filt_d  = '0;
                  cnt_d   = '0;
                  state_d = ST_HOLD;
               end else begin
                  filt_d = sat_inc(filt_q);
               end
            end
            ST_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_d        = '0;
                  dom_rst_d[0] = 1'b0;
                  if (N_DOM == 1) begin
                     state_d = ST_RUN;
                  end else begin
                     state_d = ST_RELEASE;
                     idx_d   = IDX_W'(1);
                  end
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            ST_RELEASE: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d            = '0;
                  dom_rst_d[idx_q] = 1'b0;
                  if (idx_q == IDX_LAST) begin
                     state_d = ST_RUN;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            ST_RUN: begin
               // Flags follow the state register, so they rise one cycle
               // after the last domain reset falls.
               all_ready_d = 1'b1;
               busy_d      = 1'b0;
            end
            default: begin
               state_d   = ST_ASSERT;
               dom_rst_d = ALL_ONES;
            end
         endcase
      end
   end

   // Sequencer registers; rst forces every domain into reset immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ASSERT;
         filt_q      <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         dom_rst_q   <= ALL_ONES;
         all_ready_q <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         filt_q      <= filt_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         dom_rst_q   <= dom_rst_d;
         all_ready_q <= all_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign dom_rst_out = dom_rst_q;
   assign all_ready   = all_ready_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: a 3-domain instance walked through cold
// start, lock glitch, lock loss, software restart and async reset, plus a
// 1-domain instance. Cycle numbers count rising edges after the last reset
// release; outputs are sampled 1 time unit after each edge.
module tb_rst_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst, pll_locked, sw_rst_req;
   logic [2:0] dom;
   logic       all_ready, busy;
   logic       rst1, pll1, sw1;
   logic [0:0] dom1;
   logic       ready1, busy1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   rst_seq_ctrl #(
      .N_DOM(3), .LOCK_FILTER(4), .HOLD_CYCLES(16), .GAP_CYCLES(8), .CNT_W(8)
   ) u_dut3 (
      .clk         (clk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .sw_rst_req  (sw_rst_req),
      .dom_rst_out (dom),
      .all_ready   (all_ready),
      .busy        (busy)
   );

   rst_seq_ctrl #(
      .N_DOM(1), .LOCK_FILTER(4), .HOLD_CYCLES(16), .GAP_CYCLES(8), .CNT_W(8)
   ) u_dut1 (
      .clk         (clk),
      .rst         (rst1),
      .pll_locked  (pll1),
      .sw_rst_req  (sw1),
      .dom_rst_out (dom1),
      .all_ready   (ready1),
      .busy        (busy1)
   );

   task automatic step_to(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; pll_locked = 1'b1; sw_rst_req = 1'b0;
      rst1 = 1'b0; pll1 = 1'b1; sw1 = 1'b0;
      #1;
      rst = 1'b1; rst1 = 1'b1;
      #1;
      checks++; if (dom !== 3'b111) begin errors++; $display("FAIL reset_dom got %b want %b", dom, 3'b111); end
      checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", all_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
      checks++; if (dom1 !== 1'b1) begin errors++; $display("FAIL reset_dom1 got %b want 1", dom1); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (dom !== 3'b111) begin errors++; $display("FAIL reset_hold_dom got %b want %b", dom, 3'b111); end
      rst = 1'b0; cyc = 0;
   endtask

   task automatic test_cold_start();
      step_to(21);
      checks++; if (dom !== 3'b111) begin errors++; $display("FAIL cold_pre_bit0 got %b want %b", dom, 3'b111); end
      step_to(22);
      checks++; if (dom !== 3'b110) begin errors++; $display("FAIL cold_bit0 got %b want %b", dom, 3'b110); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cold_busy_mid got %b want 1", busy); end
      step_to(29);
      checks++; if (dom !== 3'b110) begin errors++; $display("FAIL cold_pre_bit1 got %b want %b", dom, 3'b110); end
      step_to(30);
      checks++; if (dom !== 3'b100) begin errors++; $display("FAIL cold_bit1 got %b want %b", dom, 3'b100); end
      step_to(37);
      checks++; if (dom !== 3'b100) begin errors++; $display("FAIL cold_pre_bit2 got %b want %b", dom, 3'b100); end
      step_to(38);
      checks++; if (dom !== 3'b000) begin errors++; $display("FAIL cold_bit2 got %b want %b", dom, 3'b000); end
      checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL cold_ready_early got %b want 0", all_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cold_busy_early got %b want 1", busy); end
      step_to(39);
      checks++; if (all_ready !== 1'b1) begin errors++; $display("FAIL cold_ready got %b want 1", all_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cold_busy got %b want 0", busy); end
      checks++; if (dom !== 3'b000) begin errors++; $display("FAIL cold_run_dom got %b want %b", dom, 3'b000); end
   endtask

   // Lock high 3 cycles, low 2, then high: filter must restart from zero.
   task automatic test_lock_glitch();
      rst = 1'b1; pll_locked = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0; cyc = 0; pll_locked = 1'b1;
      step_to(3);
      pll_locked = 1'b0;
      step_to(5);
      pll_locked = 1'b1;
      step_to(26);
      checks++; if (dom !== 3'b111) begin errors++; $display("FAIL glitch_pre_bit0 got %b want %b", dom, 3'b111); end
      step_to(27);
      checks++; if (dom !== 3'b110) begin errors++; $display("FAIL glitch_bit0 got %b want %b", dom, 3'b110); end
   endtask

   task automatic test_lock_drop();
      pll_locked = 1'b0;
      step_to(29);
      checks++; if (dom !== 3'b110) begin errors++; $display("FAIL drop_before got %b want %b", dom, 3'b110); end
      step_to(30);
      checks++; if (dom !== 3'b111) begin errors++; $display("FAIL drop_dom got %b want %b", dom, 3'b111); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy got %b want 1", busy); end
      pll_locked = 1'b1;
      step_to(51);
      checks++; if (dom !== 3'b111) begin errors++; $display("FAIL drop_re_pre_bit0 got %b want %b", dom, 3'b111); end
      step_to(52);
      checks++; if (dom !== 3'b110) begin errors++; $display("FAIL drop_re_bit0 got %b want %b", dom, 3'b110); end
      step_to(68);
      checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL drop_re_ready_early got %b want 0", all_ready); end
      step_to(69);
      checks++; if (all_ready !== 1'b1) begin errors++; $display("FAIL drop_re_ready got %b want 1", all_ready); end
      checks++; if (dom !== 3'b000) begin errors++; $display("FAIL drop_re_dom got %b want %b", dom, 3'b000); end
   endtask

   task automatic test_sw_rst();
      step_to(70);
      sw_rst_req = 1'b1;
      step_to(71);
      sw_rst_req = 1'b0;
      checks++; if (dom !== 3'b111) begin errors++; $display("FAIL sw_dom got %b want %b", dom, 3'b111); end
      checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL sw_ready got %b want 0", all_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy got %b want 1", busy); end
      step_to(91);
      checks++; if (dom !== 3'b111) begin errors++; $display("FAIL sw_pre_bit0 got %b want %b", dom, 3'b111); end
      step_to(92);
      checks++; if (dom !== 3'b110) begin errors++; $display("FAIL sw_bit0 got %b want %b", dom, 3'b110); end
      step_to(108);
      checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL sw_ready_early got %b want 0", all_ready); end
      step_to(109);
      checks++; if (all_ready !== 1'b1) begin errors++; $display("FAIL sw_ready_back got %b want 1", all_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sw_busy_back got %b want 0", busy); end
   endtask

   task automatic test_rst_mid_release();
      step_to(110);
      sw_rst_req = 1'b1;
      step_to(111);
      sw_rst_req = 1'b0;
      step_to(135);
      checks++; if (dom !== 3'b110) begin errors++; $display("FAIL midrel_before got %b want %b", dom, 3'b110); end
      #3;
      rst = 1'b1;
      #1;
      checks++; if (dom !== 3'b111) begin errors++; $display("FAIL midrel_async_dom got %b want %b", dom, 3'b111); end
      checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL midrel_async_ready got %b want 0", all_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrel_async_busy got %b want 1", busy); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0; cyc = 0;
      step_to(22);
      checks++; if (dom !== 3'b110) begin errors++; $display("FAIL midrel_re_bit0 got %b want %b", dom, 3'b110); end
      step_to(38);
      checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL midrel_re_ready_early got %b want 0", all_ready); end
      step_to(39);
      checks++; if (all_ready !== 1'b1) begin errors++; $display("FAIL midrel_re_ready got %b want 1", all_ready); end
   endtask

   task automatic test_single_domain();
      rst1 = 1'b0; cyc = 0;
      step_to(21);
      checks++; if (dom1 !== 1'b1) begin errors++; $display("FAIL n1_pre_bit0 got %b want 1", dom1); end
      step_to(22);
      checks++; if (dom1 !== 1'b0) begin errors++; $display("FAIL n1_bit0 got %b want 0", dom1); end
      checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL n1_ready_early got %b want 0", ready1); end
      step_to(23);
      checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL n1_ready got %b want 1", ready1); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL n1_busy got %b want 0", busy1); end
      // Request held for two cycles: the second lands in ASSERT and is ignored.
      sw1 = 1'b1;
      step_to(24);
      checks++; if (dom1 !== 1'b1) begin errors++; $display("FAIL n1_sw_dom got %b want 1", dom1); end
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL n1_sw_busy got %b want 1", busy1); end
      step_to(25);
      sw1 = 1'b0;
      step_to(44);
      checks++; if (dom1 !== 1'b1) begin errors++; $display("FAIL n1_sw_pre_bit0 got %b want 1", dom1); end
      step_to(45);
      checks++; if (dom1 !== 1'b0) begin errors++; $display("FAIL n1_sw_bit0 got %b want 0", dom1); end
      checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL n1_sw_ready_early got %b want 0", ready1); end
      step_to(46);
      checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL n1_sw_ready got %b want 1", ready1); end
   endtask

   initial begin
      test_reset();
      test_cold_start();
      test_lock_glitch();
      test_lock_drop();
      test_sw_rst();
      test_rst_mid_release();
      test_single_domain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
